cbus_arbiter: RTL and testbench

- Shares the single external cbus port between NUM_REQ memory-side requesters: index 0 is the dcache/uncached path, index 1 is the icache refill path.
- Grants one requester at a time and locks the grant for a whole burst.
- Latches the address phase so the bus transaction stays legal when the owner is flushed (excpW/branchM) mid-burst.
- Its per-requester busy/grant indications feed i_wait/d_wait generation upstream of the hazard unit.

---
 rtl/cbus_arbiter_pkg.sv | 32 +++
 rtl/cbus_arbiter_arb_pick.sv | 35 +++
 rtl/cbus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cbus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus definitions: size encodings, default burst-length width,
// request/response bundles and the arbiter state encoding.
package cbus_arbiter_pkg;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;

    localparam int unsigned CBUS_LEN_W = 4;

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [2:0]            size;
        logic [31:0]           addr;
        logic [CBUS_LEN_W-1:0] len;
        logic [31:0]           data;
        logic [3:0]            strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_arb_pick.sv
// One-hot request picker: the first valid index at or after rr_ptr_i wins.
// Tie rr_ptr_i to zero for plain fixed priority (index 0 highest).
module arb_pick
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr_i) + i) % NUM_REQ);
            if (!found && valid_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Burst-locked arbiter sharing one cbus port between NUM_REQ requesters.
// Define CBUS_ARB_RR_EN for rotating priority; default is fixed priority.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned LEN_W   = CBUS_LEN_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             ireq_valid,
    input  logic [NUM_REQ-1:0]             ireq_is_write,
    input  logic [NUM_REQ-1:0][2:0]        ireq_size,
    input  logic [NUM_REQ-1:0][31:0]       ireq_addr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]  ireq_len,
    input  logic [NUM_REQ-1:0][31:0]       ireq_data,
    input  logic [NUM_REQ-1:0][3:0]        ireq_strobe,
    output logic [NUM_REQ-1:0]             iresp_ready,
    output logic [NUM_REQ-1:0]             iresp_last,
    output logic [31:0]                    iresp_data,
    output logic                           oreq_valid,
    output logic                           oreq_is_write,
    output logic [2:0]                     oreq_size,
    output logic [31:0]                    oreq_addr,
    output logic [LEN_W-1:0]               oreq_len,
    output logic [31:0]                    oreq_data,
    output logic [3:0]                     oreq_strobe,
    input  logic                           oresp_ready,
    input  logic                           oresp_last,
    input  logic [31:0]                    oresp_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           len_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               wr_q, wr_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic               len_err_q, len_err_d;
    logic [IDX_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

`ifdef CBUS_ARB_RR_EN
    logic [IDX_W-1:0]   rr_q, rr_d;
    assign rr_ptr = rr_q;
`else
    assign rr_ptr = '0;
`endif

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i  (ireq_valid),
        .rr_ptr_i (rr_ptr),
        .grant_o  (pick_grant),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            grant_q   <= '0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            len_err_q <= 1'b0;
`ifdef CBUS_ARB_RR_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            len_err_q <= len_err_d;
`ifdef CBUS_ARB_RR_EN
            rr_q      <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        len_err_d = 1'b0;
`ifdef CBUS_ARB_RR_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                    grant_d = pick_grant;
                    wr_d    = ireq_is_write[pick_idx];
                    size_d  = ireq_size[pick_idx];
                    addr_d  = ireq_addr[pick_idx];
                    len_d   = ireq_len[pick_idx];
                    beat_d  = '0;
                end
            end
            BUSY: begin
                if (oresp_ready) begin
                    beat_d    = beat_q + 1'b1;
                    // Error is advisory; termination is driven by oresp_last alone.
                    len_err_d = oresp_last ? (beat_q != len_q) : (beat_q == len_q);
                    if (oresp_last) begin
                        state_d = IDLE;
                        grant_d = '0;
`ifdef CBUS_ARB_RR_EN
                        rr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oreq_valid    = 1'b0;
        oreq_is_write = 1'b0;
        oreq_size     = '0;
        oreq_addr     = '0;
        oreq_len      = '0;
        oreq_data     = '0;
        oreq_strobe   = '0;
        iresp_ready   = '0;
        iresp_last    = '0;
        if (state_q == BUSY) begin
            oreq_valid    = 1'b1;
            oreq_is_write = wr_q;
            oreq_size     = size_q;
            oreq_addr     = addr_q;
            oreq_len      = len_q;
            // A flushed owner keeps the burst alive but must not write any bytes.
            oreq_data     = ireq_data[owner_q];
            oreq_strobe   = ireq_valid[owner_q] ? ireq_strobe[owner_q] : 4'b0000;
            iresp_ready[owner_q] = oresp_ready;
            iresp_last[owner_q]  = oresp_ready & oresp_last;
        end
    end

    assign grant      = grant_q;
    assign len_err    = len_err_q;
    assign iresp_data = oresp_data;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: expected response beats are queued when
// the downstream handshake is driven and popped when a requester sees them.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned LW = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NR-1:0]          ireq_valid;
    logic [NR-1:0]          ireq_is_write;
    logic [NR-1:0][2:0]     ireq_size;
    logic [NR-1:0][31:0]    ireq_addr;
    logic [NR-1:0][LW-1:0]  ireq_len;
    logic [NR-1:0][31:0]    ireq_data;
    logic [NR-1:0][3:0]     ireq_strobe;
    logic [NR-1:0]          iresp_ready;
    logic [NR-1:0]          iresp_last;
    logic [31:0]            iresp_data;
    logic                   oreq_valid;
    logic                   oreq_is_write;
    logic [2:0]             oreq_size;
    logic [31:0]            oreq_addr;
    logic [LW-1:0]          oreq_len;
    logic [31:0]            oreq_data;
    logic [3:0]             oreq_strobe;
    logic                   oresp_ready;
    logic                   oresp_last;
    logic [31:0]            oresp_data;
    logic [NR-1:0]          grant;
    logic                   len_err;

    cbus_arbiter #(
        .NUM_REQ (NR),
        .LEN_W   (LW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_is_write (ireq_is_write),
        .ireq_size     (ireq_size),
        .ireq_addr     (ireq_addr),
        .ireq_len      (ireq_len),
        .ireq_data     (ireq_data),
        .ireq_strobe   (ireq_strobe),
        .iresp_ready   (iresp_ready),
        .iresp_last    (iresp_last),
        .iresp_data    (iresp_data),
        .oreq_valid    (oreq_valid),
        .oreq_is_write (oreq_is_write),
        .oreq_size     (oreq_size),
        .oreq_addr     (oreq_addr),
        .oreq_len      (oreq_len),
        .oreq_data     (oreq_data),
        .oreq_strobe   (oreq_strobe),
        .oresp_ready   (oresp_ready),
        .oresp_last    (oresp_last),
        .oresp_data    (oresp_data),
        .grant         (grant),
        .len_err       (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned req;
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int r, input logic v, input logic wr, input logic [31:0] a,
                             input logic [LW-1:0] l, input logic [31:0] d, input logic [3:0] s);
        ireq_valid[r]    = v;
        ireq_is_write[r] = wr;
        ireq_size[r]     = MSIZE4;
        ireq_addr[r]     = a;
        ireq_len[r]      = l;
        ireq_data[r]     = d;
        ireq_strobe[r]   = s;
    endtask

    task automatic resp(input logic last, input logic [31:0] d, input int unsigned owner);
        exp_t e;
        oresp_ready = 1'b1;
        oresp_last  = last;
        oresp_data  = d;
        e.req  = owner;
        e.last = last;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic resp_idle();
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && (|iresp_ready)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_beat", 32'(iresp_ready), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("sb_resp_ready", 32'(iresp_ready), 32'd1 << mon_e.req);
                check_eq("sb_resp_last", 32'(iresp_last), 32'(mon_e.last) << mon_e.req);
                check_eq("sb_resp_data", iresp_data, mon_e.data);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        ireq_valid    = '0;
        ireq_is_write = '0;
        ireq_size     = '0;
        ireq_addr     = '0;
        ireq_len      = '0;
        ireq_data     = '0;
        ireq_strobe   = '0;
        resp_idle();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_oreq_valid", 32'(oreq_valid), 32'd0);
        check_eq("rst_oreq_addr", oreq_addr, 32'd0);
        check_eq("rst_len_err", 32'(len_err), 32'd0);
        reset = 1'b0;

        // Single 4-beat read from requester 1.
        step();
        drive_req(1, 1'b1, 1'b0, 32'h1FC0_0000, 4'd3, 32'd0, 4'h0);
        #1;
        check_eq("rd_no_comb_path", 32'(oreq_valid), 32'd0);
        step();
        check_eq("rd_oreq_valid", 32'(oreq_valid), 32'd1);
        check_eq("rd_grant", 32'(grant), 32'b10);
        check_eq("rd_addr", oreq_addr, 32'h1FC0_0000);
        check_eq("rd_len", 32'(oreq_len), 32'd3);
        check_eq("rd_size", 32'(oreq_size), 32'(MSIZE4));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            if (k == 3) ireq_valid[1] = 1'b0;
            resp(k == 3, 32'hD000_0000 + 32'(k), 1);
            #1;
            check_eq("rd_busy_grant", 32'(grant), 32'b10);
        end
        step();
        resp_idle();
        check_eq("rd_done_grant", 32'(grant), 32'd0);
        check_eq("rd_done_valid", 32'(oreq_valid), 32'd0);
        check_eq("rd_len_err", 32'(len_err), 32'd0);

        // Contention: both requesters raise valid in the same cycle.
        drive_req(0, 1'b1, 1'b0, 32'h0000_1000, 4'd0, 32'd0, 4'h0);
        drive_req(1, 1'b1, 1'b0, 32'h0000_2000, 4'd0, 32'd0, 4'h0);
        #1;
        check_eq("ct_no_comb_path", 32'(oreq_valid), 32'd0);
`ifdef CBUS_ARB_RR_EN
        for (int r = 0; r < 4; r++) begin
            step();
            check_eq("rr_grant", 32'(grant), (r % 2 == 0) ? 32'b01 : 32'b10);
            if (r == 3) ireq_valid = '0;
            resp(1'b1, 32'hC000_0000 + 32'(r), (r % 2 == 0) ? 0 : 1);
            step();
            resp_idle();
            check_eq("rr_dead_cycle", 32'(grant), 32'd0);
        end
`else
        for (int r = 0; r < 3; r++) begin
            step();
            check_eq("fp_grant_req0", 32'(grant), 32'b01);
            check_eq("fp_addr_req0", oreq_addr, 32'h0000_1000);
            if (r == 2) ireq_valid[0] = 1'b0;
            resp(1'b1, 32'hC000_0000 + 32'(r), 0);
            step();
            resp_idle();
            check_eq("fp_dead_cycle", 32'(grant), 32'd0);
            check_eq("fp_dead_valid", 32'(oreq_valid), 32'd0);
        end
        step();
        check_eq("fp_grant_req1", 32'(grant), 32'b10);
        check_eq("fp_addr_req1", oreq_addr, 32'h0000_2000);
        ireq_valid[1] = 1'b0;
        resp(1'b1, 32'hC000_00FF, 1);
        step();
        resp_idle();
        check_eq("fp_done_grant", 32'(grant), 32'd0);
`endif

        // Write burst from requester 0, flushed after beat 1.
        drive_req(0, 1'b1, 1'b1, 32'h8000_0040, 4'd3, 32'hA000_0000, 4'hF);
        step();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            ireq_data[0] = 32'hA000_0000 + 32'(k);
            if (k == 2) ireq_valid[0] = 1'b0;
            resp(k == 3, 32'd0, 0);
            #1;
            check_eq("fl_strobe", 32'(oreq_strobe), (k < 2) ? 32'hF : 32'h0);
            check_eq("fl_data", oreq_data, 32'hA000_0000 + 32'(k));
            check_eq("fl_addr", oreq_addr, 32'h8000_0040);
            check_eq("fl_len", 32'(oreq_len), 32'd3);
            check_eq("fl_is_write", 32'(oreq_is_write), 32'd1);
        end
        step();
        resp_idle();
        check_eq("fl_done_grant", 32'(grant), 32'd0);
        check_eq("fl_len_err", 32'(len_err), 32'd0);

        // Length error: len=1 but last arrives on beat 0.
        drive_req(1, 1'b1, 1'b0, 32'h0000_3000, 4'd1, 32'd0, 4'h0);
        step();
        check_eq("le_grant", 32'(grant), 32'b10);
        ireq_valid[1] = 1'b0;
        resp(1'b1, 32'hE000_0001, 1);
        #1;
        check_eq("le_not_yet", 32'(len_err), 32'd0);
        step();
        resp_idle();
        check_eq("le_pulse", 32'(len_err), 32'd1);
        check_eq("le_idle_grant", 32'(grant), 32'd0);
        step();
        check_eq("le_pulse_end", 32'(len_err), 32'd0);

        // Asynchronous reset during beat 2 of a read burst.
        drive_req(0, 1'b1, 1'b0, 32'h0000_4000, 4'd3, 32'd0, 4'h0);
        step();
        resp(1'b0, 32'hB000_0000, 0);
        step();
        resp(1'b0, 32'hB000_0001, 0);
        step();
        oresp_ready = 1'b1;
        oresp_last  = 1'b0;
        oresp_data  = 32'hB000_0002;
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_oreq_valid", 32'(oreq_valid), 32'd0);
        check_eq("ar_grant", 32'(grant), 32'd0);
        check_eq("ar_iresp_ready", 32'(iresp_ready), 32'd0);
        check_eq("ar_oreq_addr", oreq_addr, 32'd0);
        ireq_valid = '0;
        resp_idle();
        step();
        step();
        reset = 1'b0;
        drive_req(1, 1'b1, 1'b0, 32'h0000_5000, 4'd0, 32'd0, 4'h0);
        #1;
        check_eq("ar_post_idle", 32'(oreq_valid), 32'd0);
        step();
        check_eq("ar_post_grant", 32'(grant), 32'b10);
        check_eq("ar_post_addr", oreq_addr, 32'h0000_5000);
        ireq_valid[1] = 1'b0;
        resp(1'b1, 32'hF000_0000, 1);
        step();
        resp_idle();
        check_eq("ar_post_done", 32'(grant), 32'd0);

        step();
        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
